// File: rtl/branch_predictor_unit_if.sv
// Fetch/EX-side signal bundle for the branch predictor.
// The master drives lookup and training inputs; the slave is the predictor itself.
interface branch_predictor_unit_if #(
    parameter int unsigned PHT_IDX_W = 5
);
    logic                 f_pc_dummy_unused;
    logic [31:0]          f_pc;
    logic                 f_valid;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic [PHT_IDX_W-1:0] pht_idx;
    logic                 btb_hit;
    logic                 ex_update_en;
    logic [31:0]          ex_pc;
    logic [1:0]           ex_kind;
    logic                 ex_actual_taken;
    logic [31:0]          ex_actual_target;
    logic [PHT_IDX_W-1:0] ex_pht_idx;
    logic                 redirect_valid;

    modport master (
        output f_pc, f_valid, ex_update_en, ex_pc, ex_kind, ex_actual_taken,
               ex_actual_target, ex_pht_idx, redirect_valid,
        input  pred_taken, pred_target, pht_idx, btb_hit
    );

    modport slave (
        input  f_pc, f_valid, ex_update_en, ex_pc, ex_kind, ex_actual_taken,
               ex_actual_target, ex_pht_idx, redirect_valid,
        output pred_taken, pred_target, pht_idx, btb_hit
    );
endinterface

// File: rtl/branch_predictor_unit.sv
// gshare direction predictor + tagged direct-mapped BTB + speculative/committed return stack.
// Lookup is combinational on f_pc; training and RAS updates land on the next clock edge.
module branch_predictor_unit #(
    parameter int unsigned PHT_IDX_W = 5,
    parameter int unsigned GHR_W     = 5,
    parameter int unsigned BTB_IDX_W = 4,
    parameter int unsigned RAS_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    branch_predictor_unit_if.slave bp
);
    localparam int unsigned PHT_N  = 1 << PHT_IDX_W;
    localparam int unsigned BTB_N  = 1 << BTB_IDX_W;
    localparam int unsigned TAG_W  = 30 - BTB_IDX_W;
    localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CW = RAS_PW + 1;

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_CALL = 2'b10;
    localparam logic [1:0] KIND_RET  = 2'b11;

    logic [1:0]           r_pht        [PHT_N];
    logic [GHR_W-1:0]     r_ghr;
    logic [BTB_N-1:0]     r_btb_valid;
    logic [TAG_W-1:0]     r_btb_tag    [BTB_N];
    logic [31:0]          r_btb_target [BTB_N];
    logic [1:0]           r_btb_kind   [BTB_N];
    logic [31:0]          r_s_ras      [RAS_DEPTH];
    logic [31:0]          r_c_ras      [RAS_DEPTH];
    logic [RAS_PW-1:0]    r_s_ptr, r_c_ptr;
    logic [RAS_CW-1:0]    r_s_cnt, r_c_cnt;

    logic [BTB_IDX_W-1:0] w_f_btb_idx, w_ex_btb_idx;
    logic [TAG_W-1:0]     w_f_tag, w_ex_tag;
    logic [PHT_IDX_W-1:0] w_pht_idx;
    logic                 w_btb_hit, w_pred_taken;
    logic [1:0]           w_f_kind;
    logic [31:0]          w_f_pc_plus4, w_s_top;
    logic [31:0]          w_c_ras_d [RAS_DEPTH];
    logic [RAS_PW-1:0]    w_c_ptr_d;
    logic [RAS_CW-1:0]    w_c_cnt_d;
    logic                 w_unused;

    assign w_unused     = ^{bp.f_pc[1:0], bp.ex_pc[1:0]};
    assign w_f_btb_idx  = bp.f_pc[BTB_IDX_W+1:2];
    assign w_f_tag      = bp.f_pc[31:BTB_IDX_W+2];
    assign w_ex_btb_idx = bp.ex_pc[BTB_IDX_W+1:2];
    assign w_ex_tag     = bp.ex_pc[31:BTB_IDX_W+2];
    assign w_pht_idx    = bp.f_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);
    assign w_f_pc_plus4 = bp.f_pc + 32'd4;
    assign w_f_kind     = r_btb_kind[w_f_btb_idx];
    assign w_btb_hit    = r_btb_valid[w_f_btb_idx] && (r_btb_tag[w_f_btb_idx] == w_f_tag);
    assign w_pred_taken = w_btb_hit && ((w_f_kind != KIND_BR) || r_pht[w_pht_idx][1]);
    assign w_s_top      = r_s_ras[r_s_ptr - RAS_PW'(1)];

    always_comb begin
        bp.pred_target = w_f_pc_plus4;
        if (w_pred_taken) begin
            if (w_f_kind == KIND_RET && r_s_cnt != '0) bp.pred_target = w_s_top;
            else                                       bp.pred_target = r_btb_target[w_f_btb_idx];
        end
    end

    assign bp.pred_taken = w_pred_taken;
    assign bp.pht_idx    = w_pht_idx;
    assign bp.btb_hit    = w_btb_hit;

    // Committed RAS next state; also the image the speculative RAS restores from on redirect.
    always_comb begin
        w_c_ras_d = r_c_ras;
        w_c_ptr_d = r_c_ptr;
        w_c_cnt_d = r_c_cnt;
        if (bp.ex_update_en) begin
            if (bp.ex_kind == KIND_CALL) begin
                w_c_ras_d[r_c_ptr] = bp.ex_pc + 32'd4;
                w_c_ptr_d          = r_c_ptr + RAS_PW'(1);
                if (r_c_cnt != RAS_CW'(RAS_DEPTH)) w_c_cnt_d = r_c_cnt + RAS_CW'(1);
            end else if (bp.ex_kind == KIND_RET && r_c_cnt != '0) begin
                w_c_ptr_d = r_c_ptr - RAS_PW'(1);
                w_c_cnt_d = r_c_cnt - RAS_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
            for (int i = 0; i < BTB_N; i++) begin
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
                r_btb_kind[i]   <= '0;
            end
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_s_ras[i] <= '0;
                r_c_ras[i] <= '0;
            end
            r_ghr       <= '0;
            r_btb_valid <= '0;
            r_s_ptr     <= '0;
            r_s_cnt     <= '0;
            r_c_ptr     <= '0;
            r_c_cnt     <= '0;
        end else begin
            if (bp.ex_update_en && bp.ex_kind == KIND_BR) begin
                if (bp.ex_actual_taken && r_pht[bp.ex_pht_idx] != 2'b11)
                    r_pht[bp.ex_pht_idx] <= r_pht[bp.ex_pht_idx] + 2'b01;
                else if (!bp.ex_actual_taken && r_pht[bp.ex_pht_idx] != 2'b00)
                    r_pht[bp.ex_pht_idx] <= r_pht[bp.ex_pht_idx] - 2'b01;
                r_ghr <= GHR_W'({r_ghr, bp.ex_actual_taken});
            end
            if (bp.ex_update_en && (bp.ex_kind != KIND_BR || bp.ex_actual_taken)) begin
                r_btb_valid[w_ex_btb_idx]  <= 1'b1;
                r_btb_tag[w_ex_btb_idx]    <= w_ex_tag;
                r_btb_target[w_ex_btb_idx] <= bp.ex_actual_target;
                r_btb_kind[w_ex_btb_idx]   <= bp.ex_kind;
            end
            r_c_ras <= w_c_ras_d;
            r_c_ptr <= w_c_ptr_d;
            r_c_cnt <= w_c_cnt_d;
            // Redirect wins over any fetch-side push/pop in the same cycle.
            if (bp.redirect_valid) begin
                r_s_ras <= w_c_ras_d;
                r_s_ptr <= w_c_ptr_d;
                r_s_cnt <= w_c_cnt_d;
            end else if (bp.f_valid && w_btb_hit) begin
                if (w_f_kind == KIND_CALL) begin
                    r_s_ras[r_s_ptr] <= w_f_pc_plus4;
                    r_s_ptr          <= r_s_ptr + RAS_PW'(1);
                    if (r_s_cnt != RAS_CW'(RAS_DEPTH)) r_s_cnt <= r_s_cnt + RAS_CW'(1);
                end else if (w_f_kind == KIND_RET && r_s_cnt != '0) begin
                    r_s_ptr <= r_s_ptr - RAS_PW'(1);
                    r_s_cnt <= r_s_cnt - RAS_CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Vector-table bench for branch_predictor_unit: each record is one cycle of stimulus plus the
// lookup outputs expected in that cycle (before the edge applies its updates).
module tb_branch_predictor_unit;
    logic clk;
    logic rst;

    branch_predictor_unit_if #(.PHT_IDX_W(5)) bp_if ();

    branch_predictor_unit #(
        .PHT_IDX_W(5),
        .GHR_W    (5),
        .BTB_IDX_W(4),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] f_pc;
        logic        fv;
        logic        redir;
        logic        ex_en;
        logic [31:0] ex_pc;
        logic [1:0]  kind;
        logic        tk;
        logic [31:0] tgt;
        logic [4:0]  pidx;
        logic        chk;
        logic        hit;
        logic        ptaken;
        logic [31:0] ptgt;
        logic [4:0]  idx;
    } vec_t;

    typedef struct packed {
        logic        hit;
        logic        ptaken;
        logic [31:0] ptgt;
        logic [4:0]  idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int unsigned r, input int unsigned pc, input int unsigned fv,
                                input int unsigned rd, input int unsigned en,
                                input int unsigned epc, input int unsigned k,
                                input int unsigned tk, input int unsigned tgt,
                                input int unsigned pidx, input int unsigned chk,
                                input int unsigned hit, input int unsigned pt,
                                input int unsigned ptgt, input int unsigned idx);
        vec_t v;
        v.rst    = (r != 0);
        v.f_pc   = pc;
        v.fv     = (fv != 0);
        v.redir  = (rd != 0);
        v.ex_en  = (en != 0);
        v.ex_pc  = epc;
        v.kind   = 2'(k);
        v.tk     = (tk != 0);
        v.tgt    = tgt;
        v.pidx   = 5'(pidx);
        v.chk    = (chk != 0);
        v.hit    = (hit != 0);
        v.ptaken = (pt != 0);
        v.ptgt   = ptgt;
        v.idx    = 5'(idx);
        return v;
    endfunction

    task automatic apply(input vec_t v, input int id);
        exp_t got;
        exp_t e;
        @(negedge clk);
        rst                    = v.rst;
        bp_if.f_pc             = v.f_pc;
        bp_if.f_valid          = v.fv;
        bp_if.redirect_valid   = v.redir;
        bp_if.ex_update_en     = v.ex_en;
        bp_if.ex_pc            = v.ex_pc;
        bp_if.ex_kind          = v.kind;
        bp_if.ex_actual_taken  = v.tk;
        bp_if.ex_actual_target = v.tgt;
        bp_if.ex_pht_idx       = v.pidx;
        if (v.chk) sb.push_back('{hit: v.hit, ptaken: v.ptaken, ptgt: v.ptgt, idx: v.idx});
        #2;
        if (v.chk) begin
            got = '{hit: bp_if.btb_hit, ptaken: bp_if.pred_taken, ptgt: bp_if.pred_target,
                    idx: bp_if.pht_idx};
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL vec%0d f_pc=%h: got hit=%b taken=%b target=%h idx=%h, want hit=%b taken=%b target=%h idx=%h",
                         id, v.f_pc, got.hit, got.ptaken, got.ptgt, got.idx,
                         e.hit, e.ptaken, e.ptgt, e.idx);
            end
        end
    endtask

    initial begin
        rst                    = 1'b1;
        bp_if.f_pc             = '0;
        bp_if.f_valid          = 1'b0;
        bp_if.redirect_valid   = 1'b0;
        bp_if.ex_update_en     = 1'b0;
        bp_if.ex_pc            = '0;
        bp_if.ex_kind          = '0;
        bp_if.ex_actual_taken  = 1'b0;
        bp_if.ex_actual_target = '0;
        bp_if.ex_pht_idx       = '0;

        //                 rst pc    fv rd  en epc   k tk tgt    pidx chk hit pt ptgt   idx
        vecs.push_back(mk(1, 'h100, 0, 0, 0, 0,    0, 0, 0,     0,    0,  0, 0, 0,     0));
        vecs.push_back(mk(0, 'h100, 0, 0, 0, 0,    0, 0, 0,     0,    1,  0, 0, 'h104, 'h00));
        // Conditional branch training and gshare indexing.
        vecs.push_back(mk(0, 'h200, 0, 0, 1, 'h200, 0, 1, 'h180, 'h00, 1,  0, 0, 'h204, 'h00));
        vecs.push_back(mk(0, 'h200, 0, 0, 1, 'h200, 0, 1, 'h180, 'h00, 1,  1, 0, 'h204, 'h01));
        vecs.push_back(mk(0, 'h200, 0, 0, 0, 0,    0, 0, 0,     0,    1,  1, 0, 'h204, 'h03));
        vecs.push_back(mk(0, 'h200, 0, 0, 1, 'h200, 0, 1, 'h180, 'h03, 1,  1, 0, 'h204, 'h03));
        vecs.push_back(mk(0, 'h200, 0, 0, 1, 'h200, 0, 1, 'h180, 'h07, 1,  1, 0, 'h204, 'h07));
        vecs.push_back(mk(0, 'h200, 0, 0, 1, 'h200, 0, 1, 'h180, 'h1F, 1,  1, 0, 'h204, 'h0F));
        vecs.push_back(mk(0, 'h200, 0, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h180, 'h1F));
        // Not-taken branch must not allocate.
        vecs.push_back(mk(0, 'h240, 0, 0, 1, 'h240, 0, 0, 'h999, 'h1F, 1,  0, 0, 'h244, 'h0F));
        vecs.push_back(mk(0, 'h240, 0, 0, 0, 0,    0, 0, 0,     0,    1,  0, 0, 'h244, 'h0E));
        vecs.push_back(mk(0, 'h200, 0, 0, 0, 0,    0, 0, 0,     0,    1,  1, 0, 'h204, 'h1E));
        // Call at 0x300, return at 0x410 (BTB target 0x7F0 to tell it apart from the RAS).
        vecs.push_back(mk(0, 'h300, 0, 0, 1, 'h300, 2, 1, 'h400, 0,    1,  0, 0, 'h304, 'h1E));
        vecs.push_back(mk(0, 'h410, 0, 0, 1, 'h410, 3, 1, 'h7F0, 0,    1,  0, 0, 'h414, 'h1A));
        vecs.push_back(mk(0, 'h300, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1E));
        vecs.push_back(mk(0, 'h410, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h304, 'h1A));
        // Four more call sites, then fill the RAS past its depth.
        vecs.push_back(mk(0, 'h304, 0, 0, 1, 'h304, 2, 1, 'h400, 0,    1,  0, 0, 'h308, 'h1F));
        vecs.push_back(mk(0, 'h308, 0, 0, 1, 'h308, 2, 1, 'h400, 0,    1,  0, 0, 'h30C, 'h1C));
        vecs.push_back(mk(0, 'h30C, 0, 0, 1, 'h30C, 2, 1, 'h400, 0,    1,  0, 0, 'h310, 'h1D));
        vecs.push_back(mk(0, 'h314, 0, 0, 1, 'h314, 2, 1, 'h400, 0,    1,  0, 0, 'h318, 'h1B));
        vecs.push_back(mk(0, 'h300, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1E));
        vecs.push_back(mk(0, 'h304, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1F));
        vecs.push_back(mk(0, 'h308, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1C));
        vecs.push_back(mk(0, 'h30C, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1D));
        vecs.push_back(mk(0, 'h314, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1B));
        vecs.push_back(mk(0, 'h410, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h318, 'h1A));
        vecs.push_back(mk(0, 'h410, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h310, 'h1A));
        vecs.push_back(mk(0, 'h410, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h30C, 'h1A));
        vecs.push_back(mk(0, 'h410, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h308, 'h1A));
        vecs.push_back(mk(0, 'h410, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h7F0, 'h1A));
        // Drain the committed RAS with resolved returns.
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 'h100, 0, 0, 1, 'h410, 3, 1, 'h7F0, 0, 1, 0, 0, 'h104, 'h1E));
        // Speculative push, then redirect (with a same-cycle push that must be dropped).
        vecs.push_back(mk(0, 'h300, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1E));
        vecs.push_back(mk(0, 'h300, 1, 1, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1E));
        vecs.push_back(mk(0, 'h410, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h7F0, 'h1A));
        // Redirect in the same cycle as a resolved call restores the post-update committed stack.
        vecs.push_back(mk(0, 'h100, 0, 1, 1, 'h300, 2, 1, 'h400, 0,    1,  0, 0, 'h104, 'h1E));
        vecs.push_back(mk(0, 'h410, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h304, 'h1A));
        vecs.push_back(mk(0, 'h300, 1, 0, 0, 0,    0, 0, 0,     0,    1,  1, 1, 'h400, 'h1E));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Mid-stream reset: activity during the reset cycle is ignored, all state cleared.
        apply(mk(1, 'h300, 1, 1, 1, 'h21C, 2, 1, 'h999, 'h07, 0, 0, 0, 0, 0), 100);
        apply(mk(0, 'h300, 0, 0, 1, 'h208, 0, 1, 'h180, 'h1F, 1, 0, 0, 'h304, 'h00), 101);
        apply(mk(0, 'h410, 1, 0, 0, 0,     0, 0, 0,     0,    1, 0, 0, 'h414, 'h05), 102);
        apply(mk(0, 'h208, 0, 0, 1, 'h410, 3, 1, 'h7F0, 0,    1, 1, 0, 'h20C, 'h03), 103);
        apply(mk(0, 'h410, 1, 0, 0, 0,     0, 0, 0,     0,    1, 1, 1, 'h7F0, 'h05), 104);
        apply(mk(0, 'h21C, 0, 0, 0, 0,     0, 0, 0,     0,    1, 0, 0, 'h220, 'h06), 105);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
